// File: rtl/vga_pkg.sv
// Shared definitions for the VGA pixel pipeline: pattern mode encodings,
// default geometry and the bounce-step helper used by the box mover.
package vga_pkg;

    typedef enum logic [2:0] {
        MODE_SOLID   = 3'b000,
        MODE_VBARS   = 3'b001,
        MODE_HBARS   = 3'b010,
        MODE_CHECKER = 3'b011,
        MODE_SCROLL  = 3'b100,
        MODE_BOX     = 3'b101,
        MODE_BORDER  = 3'b110,
        MODE_OFF     = 3'b111
    } mode_e;

    localparam int H_VIS_DEF = 640;
    localparam int V_VIS_DEF = 480;
    localparam int BOX_DEF   = 32;

    localparam logic [9:0] BOX_X0 = 10'd304;
    localparam logic [9:0] BOX_Y0 = 10'd224;

    // One axis of box motion; returns {dir, pos}. Reversal and the first
    // step away from the wall happen in the same tick.
    function automatic logic [10:0] bounce_step(input logic [9:0] pos,
                                                input logic       dir,
                                                input logic [9:0] lim);
        logic [10:0] res;
        if (dir && (pos == lim)) begin
            res = {1'b0, pos - 10'd1};
        end else if (!dir && (pos == 10'd0)) begin
            res = {1'b1, 10'd1};
        end else if (dir) begin
            res = {1'b1, pos + 10'd1};
        end else begin
            res = {1'b0, pos - 10'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position state; advances one pixel per axis on each step pulse
// and reverses direction at the visible-area walls.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int H_VIS = H_VIS_DEF,
    parameter int V_VIS = V_VIS_DEF,
    parameter int BOX   = BOX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    output logic [9:0] bx,
    output logic [9:0] by
);

    localparam logic [9:0] BX_MAX = 10'(H_VIS - BOX);
    localparam logic [9:0] BY_MAX = 10'(V_VIS - BOX);

    logic [9:0] bx_r, by_r;
    logic       dx_r, dy_r;
    logic [9:0] bx_nxt_s, by_nxt_s;
    logic       dx_nxt_s, dy_nxt_s;

    // Next position/direction for both axes
    always_comb begin
        bx_nxt_s = bx_r;
        by_nxt_s = by_r;
        dx_nxt_s = dx_r;
        dy_nxt_s = dy_r;
        if (step) begin
            {dx_nxt_s, bx_nxt_s} = bounce_step(bx_r, dx_r, BX_MAX);
            {dy_nxt_s, by_nxt_s} = bounce_step(by_r, dy_r, BY_MAX);
        end else begin
            bx_nxt_s = bx_r;
            by_nxt_s = by_r;
        end
    end

    // Box state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            bx_r <= BOX_X0;
            by_r <= BOX_Y0;
            dx_r <= 1'b1;
            dy_r <= 1'b1;
        end else begin
            bx_r <= bx_nxt_s;
            by_r <= by_nxt_s;
            dx_r <= dx_nxt_s;
            dy_r <= dy_nxt_s;
        end
    end

    assign bx = bx_r;
    assign by = by_r;

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel stage behind vga_sync: two-stage pipeline producing a
// registered rgb with hsync/vsync delayed to match; settings latch per frame.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_VIS = H_VIS_DEF,
    parameter int V_VIS = V_VIS_DEF,
    parameter int BOX   = BOX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] sw,
    input  logic [2:0] fg,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb,
    output logic       frame_tick
);

    localparam logic [9:0]  X_LAST  = 10'(H_VIS - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_VIS - 1);
    localparam logic [9:0]  Y_BLANK = 10'(V_VIS);
    localparam logic [10:0] BOX_W   = 11'(BOX);

    logic [9:0] x1_r, y1_r;
    logic       von1_r, hs1_r, vs1_r;
    logic [2:0] rgb_r;
    logic       hs2_r, vs2_r, frame_tick_r;
    mode_e      mode_r;
    logic [2:0] fg_r;
    logic [5:0] frame_cnt_r;
    logic       tick_s, box_step_s, in_box_s;
    logic [9:0] bx_s, by_s;
    logic [2:0] rgb_s;

    // Start of vertical blank; latching and box motion share this edge.
    assign tick_s     = p_tick && (pixel_x == 10'd0) && (pixel_y == Y_BLANK);
    assign box_step_s = tick_s && (mode_r == MODE_BOX);

    vga_box_mover #(
        .H_VIS (H_VIS),
        .V_VIS (V_VIS),
        .BOX   (BOX)
    ) u_box (
        .clk   (clk),
        .reset (reset),
        .step  (box_step_s),
        .bx    (bx_s),
        .by    (by_s)
    );

    // Stage 1: capture coordinates and sync inputs every clk
    always_ff @(posedge clk) begin
        if (!reset) begin
            x1_r   <= 10'd0;
            y1_r   <= 10'd0;
            von1_r <= 1'b0;
            hs1_r  <= 1'b0;
            vs1_r  <= 1'b0;
        end else begin
            x1_r   <= pixel_x;
            y1_r   <= pixel_y;
            von1_r <= video_on;
            hs1_r  <= hsync_in;
            vs1_r  <= vsync_in;
        end
    end

    // Per-frame settings, changed only at the frame tick
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_r      <= MODE_SOLID;
            fg_r        <= 3'b000;
            frame_cnt_r <= 6'd0;
        end else if (tick_s) begin
            mode_r      <= mode_e'(sw);
            fg_r        <= fg;
            frame_cnt_r <= frame_cnt_r + 6'd1;
        end else begin
            mode_r      <= mode_r;
            fg_r        <= fg_r;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // 11-bit compare so bx+BOX cannot wrap
    assign in_box_s = ({1'b0, x1_r} >= {1'b0, bx_s}) &&
                      ({1'b0, x1_r} <  ({1'b0, bx_s} + BOX_W)) &&
                      ({1'b0, y1_r} >= {1'b0, by_s}) &&
                      ({1'b0, y1_r} <  ({1'b0, by_s} + BOX_W));

    // Pattern mux with blanking override
    always_comb begin
        rgb_s = 3'b000;
        if (von1_r) begin
            case (mode_r)
                MODE_SOLID:   rgb_s = fg_r;
                MODE_VBARS:   rgb_s = x1_r[8:6];
                MODE_HBARS:   rgb_s = y1_r[8:6];
                MODE_CHECKER: rgb_s = (x1_r[5] ^ y1_r[5]) ? fg_r : ~fg_r;
                MODE_SCROLL:  rgb_s = x1_r[8:6] + frame_cnt_r[5:3];
                MODE_BOX:     rgb_s = in_box_s ? fg_r : 3'b000;
                MODE_BORDER:  rgb_s = ((x1_r == 10'd0) || (x1_r == X_LAST) ||
                                       (y1_r == 10'd0) || (y1_r == Y_LAST)) ? 3'b111 : 3'b000;
                MODE_OFF:     rgb_s = 3'b000;
                default:      rgb_s = 3'b000;
            endcase
        end else begin
            rgb_s = 3'b000;
        end
    end

    // Stage 2: registered colour, aligned syncs and the frame tick pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb_r        <= 3'b000;
            hs2_r        <= 1'b0;
            vs2_r        <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            rgb_r        <= rgb_s;
            hs2_r        <= hs1_r;
            vs2_r        <= vs1_r;
            frame_tick_r <= tick_s;
        end
    end

    assign rgb        = rgb_r;
    assign hsync      = hs2_r;
    assign vsync      = vs2_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized self-checking bench for vga_pattern_gen against a frame-level
// reference model of the pattern rules.
module tb_vga_pattern_gen;

    localparam int H_VIS = 640;
    localparam int V_VIS = 480;
    localparam int BOX   = 32;

    logic       clk = 1'b0;
    logic       reset, p_tick, video_on, hsync_in, vsync_in;
    logic [9:0] pixel_x, pixel_y;
    logic [2:0] sw, fg;
    logic       hsync, vsync, frame_tick;
    logic [2:0] rgb;

    always #5 clk = ~clk;

    vga_pattern_gen #(.H_VIS(H_VIS), .V_VIS(V_VIS), .BOX(BOX)) dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .sw         (sw),
        .fg         (fg),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb        (rgb),
        .frame_tick (frame_tick)
    );

    int errors = 0;
    int checks = 0;

    // Values applied at the next cycle() call
    bit       nxt_rst = 1'b0;
    bit [2:0] nxt_sw  = 3'd0;
    bit [2:0] nxt_fg  = 3'd0;

    // Reference model state
    int m_mode, m_fg, m_fc, m_bx, m_by, m_dx, m_dy;
    // Expected outputs in flight: e1 = driven last cycle, e2 = two cycles ago
    int e1_rgb = 0, e2_rgb = 0;
    bit e1_hs = 0, e2_hs = 0, e1_vs = 0, e2_vs = 0, e_ft = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_fg = 0; m_fc = 0;
        m_bx = 304; m_by = 224; m_dx = 1; m_dy = 1;
    endtask

    task automatic model_tick();
        if (m_mode == 5) begin
            if (m_dx == 1) begin
                if (m_bx == H_VIS - BOX) begin m_dx = 0; m_bx = m_bx - 1; end
                else m_bx = m_bx + 1;
            end else begin
                if (m_bx == 0) begin m_dx = 1; m_bx = 1; end
                else m_bx = m_bx - 1;
            end
            if (m_dy == 1) begin
                if (m_by == V_VIS - BOX) begin m_dy = 0; m_by = m_by - 1; end
                else m_by = m_by + 1;
            end else begin
                if (m_by == 0) begin m_dy = 1; m_by = 1; end
                else m_by = m_by - 1;
            end
        end
        m_mode = int'(nxt_sw);
        m_fg   = int'(nxt_fg);
        m_fc   = (m_fc + 1) % 64;
    endtask

    function automatic int model_rgb(input int x, input int y, input bit von);
        if (!von) return 0;
        case (m_mode)
            0: return m_fg;
            1: return (x / 64) % 8;
            2: return (y / 64) % 8;
            3: return (((x / 32) % 2) != ((y / 32) % 2)) ? m_fg : 7 - m_fg;
            4: return ((x / 64) + (m_fc / 8)) % 8;
            5: return (x >= m_bx && x < m_bx + BOX && y >= m_by && y < m_by + BOX) ? m_fg : 0;
            6: return (x == 0 || x == H_VIS - 1 || y == 0 || y == V_VIS - 1) ? 7 : 0;
            default: return 0;
        endcase
    endfunction

    // One clk: check outputs due now, then drive the next input set
    task automatic cycle(input int xi, input int yi, input bit von, input bit hs,
                         input bit vs, input bit pt);
        int x, y;
        bit tk;
        x = xi & 1023;
        y = yi & 1023;
        @(negedge clk);
        check("rgb", 32'(rgb), 32'(e2_rgb));
        check("hsync", 32'(hsync), 32'(e2_hs));
        check("vsync", 32'(vsync), 32'(e2_vs));
        check("frame_tick", 32'(frame_tick), 32'(e_ft));
        reset    = ~nxt_rst;
        sw       = nxt_sw;
        fg       = nxt_fg;
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = von;
        hsync_in = hs;
        vsync_in = vs;
        p_tick   = pt;
        e2_rgb = e1_rgb; e2_hs = e1_hs; e2_vs = e1_vs;
        if (nxt_rst) begin
            model_reset();
            e2_rgb = 0; e2_hs = 0; e2_vs = 0;
            e1_rgb = 0; e1_hs = 0; e1_vs = 0; e_ft = 0;
        end else begin
            tk = pt && (x == 0) && (y == V_VIS);
            if (tk) model_tick();
            e1_rgb = model_rgb(x, y, von);
            e1_hs = hs; e1_vs = vs; e_ft = tk;
        end
    endtask

    task automatic tick();
        cycle(0, V_VIS, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic pix(input int x, input int y);
        cycle(x, y, 1'b1, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset(input int n);
        nxt_rst = 1'b1;
        for (int i = 0; i < n; i++) cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        nxt_rst = 1'b0;
    endtask

    initial begin
        reset = 1'b0; sw = 3'd0; fg = 3'd0; pixel_x = 10'd0; pixel_y = 10'd0;
        video_on = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; p_tick = 1'b0;
        model_reset();

        // Reset, then mode must stay solid/000 until the first tick
        do_reset(3);
        nxt_sw = 3'b011; nxt_fg = 3'b110;
        for (int i = 0; i < 20; i++) pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));

        // Vertical bars across a full line
        nxt_sw = 3'b001; nxt_fg = 3'b101;
        tick();
        for (int x = 0; x < H_VIS; x++) pix(x, 100);

        // Mid-frame switch change must not tear the frame
        nxt_sw = 3'b000; nxt_fg = 3'b011;
        tick();
        pix(5, 5);
        nxt_sw = 3'b011;
        for (int i = 0; i < 10; i++) pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
        tick();
        pix(0, 0); pix(32, 0); pix(32, 32); pix(0, 32);
        for (int i = 0; i < 20; i++) pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));

        // Scrolling bars over 16 frames
        do_reset(1);
        nxt_sw = 3'b100; nxt_fg = 3'b001;
        for (int f = 0; f < 17; f++) begin
            tick();
            pix(0, int'($urandom_range(0, 479)));
            pix(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
        end

        // Bouncing box through both wall reversals
        do_reset(1);
        nxt_sw = 3'b101; nxt_fg = 3'b010;
        tick();
        for (int f = 0; f < 700; f++) begin
            nxt_fg = 3'($urandom_range(1, 7));
            tick();
            pix(m_bx, m_by);
            pix(m_bx + BOX, m_by);
            pix(m_bx - 1, m_by);
            pix(m_bx + BOX - 1, m_by + BOX - 1);
            pix(m_bx, m_by + BOX);
        end

        // Border, blanking and sync pulse alignment
        nxt_sw = 3'b110;
        tick();
        pix(0, 200); pix(639, 200); pix(300, 0); pix(300, 479); pix(300, 200); pix(638, 478);
        cycle(0, 200, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(650 + i, 490, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(660 + i, 490, 1'b0, 1'b0, 1'b1, 1'b1);
        nxt_sw = 3'b111;
        tick();
        pix(0, 0); pix(100, 100);

        // Fully random traffic with occasional ticks and resets
        for (int i = 0; i < 2000; i++) begin
            if (i % 40 == 0) begin
                nxt_sw = 3'($urandom_range(0, 7));
                nxt_fg = 3'($urandom_range(0, 7));
            end
            nxt_rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) tick();
            else cycle(int'($urandom_range(0, 1023)), int'($urandom_range(0, 524)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        nxt_rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
